// File: rtl/ccm_bank_arb_pkg.sv
// ============================================================================
// Module : swerv_types (package)
// Brief  : Shared CCM request type, default geometry and sizing helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package swerv_types;

  localparam int CCM_DATA_WIDTH = 32;
  localparam int CCM_ADDR_WIDTH = 16;
  localparam int CCM_BANK_BITS  = 2;
  localparam int CCM_ROW_BITS   = 10;
  localparam int CCM_BYTES      = CCM_DATA_WIDTH / 8;

  typedef struct packed {
    logic                      we;
    logic [CCM_ADDR_WIDTH-1:0] addr;
    logic [CCM_DATA_WIDTH-1:0] wdata;
    logic [CCM_BYTES-1:0]      wstrb;
  } ccm_req_t;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccm_bank_ram.sv
// ============================================================================
// Module : ccm_bank_ram
// Brief  : One CCM bank: byte-lane write enables, registered read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ccm_bank_ram
  import swerv_types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int ROW_W      = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [ROW_W-1:0]        row,
  input  logic [WORD_W-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [WORD_W-1:0]       rdata
);

  localparam int c_bytes = DATA_WIDTH / 8;

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] w_bitmask;

  // Any bits above DATA_WIDTH are per-lane parity and follow their byte's enable.
  for (genvar l = 0; l < c_bytes; l++) begin : g_lane
    assign w_bitmask[8*l +: 8] = {8{be[l]}};
    if (WORD_W > DATA_WIDTH) begin : g_par
      assign w_bitmask[DATA_WIDTH+l] = be[l];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (w_bitmask[i]) r_mem[row][i] <= wdata[i];
      end
    end
    if (rd_en) r_rdata <= r_mem[row];
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ccm_bank_arb.sv
// ============================================================================
// Module : ccm_bank_arb
// Brief  : Multi-channel banked CCM with per-bank round-robin arbitration.
//          Optional byte parity enabled by defining RV_CCM_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ccm_bank_arb
  import swerv_types::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 1024,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_l,
  input  logic                                    freeze,
  input  logic [NUM_CH-1:0]                       req_valid,
  output logic [NUM_CH-1:0]                       req_ready,
  input  logic [NUM_CH-1:0]                       req_we,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]       req_wdata,
  input  logic [NUM_CH-1:0][DATA_WIDTH/8-1:0]     req_wstrb,
  output logic [NUM_CH-1:0]                       rsp_valid,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]       rsp_rdata,
  output logic [NUM_CH-1:0]                       rsp_err
);

  localparam int c_bytes    = DATA_WIDTH / 8;
  localparam int c_bank_log = $clog2(NUM_BANKS);
  localparam int c_bsel_w   = clog2_min1(NUM_BANKS);
  localparam int c_row_w    = clog2_min1(BANK_DEPTH);
  localparam int c_ch_w     = clog2_min1(NUM_CH);
`ifdef RV_CCM_PARITY_EN
  localparam int c_par_w    = c_bytes;
`else
  localparam int c_par_w    = 0;
`endif
  localparam int c_word_w   = DATA_WIDTH + c_par_w;
  localparam logic [ADDR_WIDTH:0] c_limit = (ADDR_WIDTH+1)'(NUM_BANKS * BANK_DEPTH);

  // ---------------- per-channel address decode ----------------
  logic [NUM_CH-1:0][c_bsel_w-1:0] w_bank;
  logic [NUM_CH-1:0][c_row_w-1:0]  w_row;
  logic [NUM_CH-1:0]               w_oor;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_dec
    if (c_bank_log > 0) begin : g_sel
      assign w_bank[c] = req_addr[c][c_bsel_w-1:0];
    end else begin : g_nosel
      assign w_bank[c] = '0;
    end
    assign w_row[c] = req_addr[c][c_bank_log +: c_row_w];
    assign w_oor[c] = {1'b0, req_addr[c]} >= c_limit;
  end

  // ---------------- per-bank round-robin arbitration ----------------
  logic [NUM_BANKS-1:0][c_ch_w-1:0] r_rr;
  logic [NUM_BANKS-1:0][c_ch_w-1:0] w_rr_nxt;
  logic [NUM_BANKS-1:0][c_ch_w-1:0] w_bank_win;
  logic [NUM_BANKS-1:0]             w_bank_gnt;
  logic [NUM_CH-1:0]                w_grant;
  logic                             w_arb_en;

  assign w_arb_en = rst_l & ~freeze;

  // A channel targets exactly one bank, so it can win at most one grant.
  always_comb begin : p_arb
    logic [c_ch_w-1:0] v_idx;
    v_idx      = '0;
    w_bank_gnt = '0;
    w_bank_win = '0;
    w_grant    = '0;
    w_rr_nxt   = r_rr;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        v_idx = c_ch_w'((int'(r_rr[b]) + k) % NUM_CH);
        if (w_arb_en && !w_bank_gnt[b] && req_valid[v_idx] &&
            (w_bank[v_idx] == c_bsel_w'(b))) begin
          w_bank_gnt[b] = 1'b1;
          w_bank_win[b] = v_idx;
          w_grant[v_idx] = 1'b1;
          w_rr_nxt[b]   = c_ch_w'((int'(v_idx) + 1) % NUM_CH);
        end
      end
    end
  end

  assign req_ready = w_grant;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_rr <= '0;
    else        r_rr <= w_rr_nxt;
  end

  // ---------------- bank arrays ----------------
  logic [NUM_BANKS-1:0][c_word_w-1:0] w_bank_rword;
  logic [NUM_BANKS-1:0]               w_bank_perr;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [c_ch_w-1:0]     w_win;
    logic                  w_wr;
    logic                  w_rd;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [c_word_w-1:0]   w_wword;
    logic [c_word_w-1:0]   w_rword;

    assign w_win   = w_bank_win[b];
    assign w_wdata = req_wdata[w_win];
    // Out-of-range accesses are granted but never touch the array.
    assign w_wr = w_bank_gnt[b] &  req_we[w_win] & ~w_oor[w_win];
    assign w_rd = w_bank_gnt[b] & ~req_we[w_win] & ~w_oor[w_win];

`ifdef RV_CCM_PARITY_EN
    logic [c_bytes-1:0] w_wpar;
    logic [c_bytes-1:0] w_rmis;
    for (genvar l = 0; l < c_bytes; l++) begin : g_par
      assign w_wpar[l] = ^w_wdata[8*l +: 8];
      assign w_rmis[l] = ^{w_rword[DATA_WIDTH+l], w_rword[8*l +: 8]};
    end
    assign w_wword        = {w_wpar, w_wdata};
    assign w_bank_perr[b] = |w_rmis;
`else
    assign w_wword        = w_wdata;
    assign w_bank_perr[b] = 1'b0;
`endif

    ccm_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_W     (c_word_w),
      .DEPTH      (BANK_DEPTH),
      .ROW_W      (c_row_w)
    ) u_ram (
      .clk   (clk),
      .wr_en (w_wr),
      .rd_en (w_rd),
      .row   (w_row[w_win]),
      .wdata (w_wword),
      .be    (req_wstrb[w_win]),
      .rdata (w_rword)
    );

    assign w_bank_rword[b] = w_rword;
  end

  // ---------------- response routing ----------------
  logic [NUM_CH-1:0]                 r_pend;
  logic [NUM_CH-1:0]                 r_pend_oor;
  logic [NUM_CH-1:0][c_bsel_w-1:0]   r_pend_bank;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] r_hold_data;
  logic [NUM_CH-1:0]                 r_hold_err;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] w_rsp_data;
  logic [NUM_CH-1:0]                 w_rsp_err;

  always_comb begin
    w_rsp_data = '0;
    w_rsp_err  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_rsp_data[c] = r_pend_oor[c] ? '0 : w_bank_rword[r_pend_bank[c]][DATA_WIDTH-1:0];
      w_rsp_err[c]  = r_pend_oor[c] | w_bank_perr[r_pend_bank[c]];
    end
  end

  // The hold registers keep the last response visible between (and during freeze).
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_pend      <= '0;
      r_pend_oor  <= '0;
      r_pend_bank <= '0;
      r_hold_data <= '0;
      r_hold_err  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_pend[c] <= w_grant[c] & ~req_we[c];
        if (w_grant[c]) begin
          r_pend_bank[c] <= w_bank[c];
          r_pend_oor[c]  <= w_oor[c];
        end
        if (r_pend[c]) begin
          r_hold_data[c] <= w_rsp_data[c];
          r_hold_err[c]  <= w_rsp_err[c];
        end
      end
    end
  end

  assign rsp_valid = r_pend;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_rsp
    assign rsp_rdata[c] = r_pend[c] ? w_rsp_data[c] : r_hold_data[c];
    assign rsp_err[c]   = r_pend[c] ? w_rsp_err[c]  : r_hold_err[c];
  end

endmodule

`default_nettype wire

// File: tb/tb_ccm_bank_arb.sv
// ============================================================================
// Module : tb_ccm_bank_arb
// Brief  : Self-checking bench for ccm_bank_arb with a word-level memory model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ccm_bank_arb;

  localparam int NCH   = 2;
  localparam int NB    = 4;
  localparam int DEPTH = 1024;
  localparam int AW    = 16;
  localparam int DW    = 32;

  logic                     clk = 1'b0;
  logic                     rst_l = 1'b0;
  logic                     freeze = 1'b0;
  logic [NCH-1:0]           req_valid;
  logic [NCH-1:0]           req_ready;
  logic [NCH-1:0]           req_we;
  logic [NCH-1:0][AW-1:0]   req_addr;
  logic [NCH-1:0][DW-1:0]   req_wdata;
  logic [NCH-1:0][DW/8-1:0] req_wstrb;
  logic [NCH-1:0]           rsp_valid;
  logic [NCH-1:0][DW-1:0]   rsp_rdata;
  logic [NCH-1:0]           rsp_err;

  always #5 clk = ~clk;

  ccm_bank_arb #(
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB),
    .BANK_DEPTH (DEPTH),
    .NUM_CH     (NCH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .freeze    (freeze),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  int          m_rr [NB];
  logic [31:0] m_mem [int];
  bit          m_bad [int];
  logic [NCH-1:0] m_gnt = '0;
  logic [NCH-1:0] m_vld = '0;
  logic [31:0]    m_data [NCH];
  logic           m_err  [NCH];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner per bank: the valid requester closest (cyclically) after the pointer.
  function automatic logic [NCH-1:0] model_grants();
    logic [NCH-1:0] g;
    int b;
    bit win;
    g = '0;
    if (!rst_l || freeze) return g;
    for (int c = 0; c < NCH; c++) begin
      if (req_valid[c]) begin
        b   = int'(req_addr[c]) % NB;
        win = 1'b1;
        for (int d = 0; d < NCH; d++) begin
          if (d != c && req_valid[d] && (int'(req_addr[d]) % NB) == b &&
              ((d - m_rr[b] + NCH) % NCH) < ((c - m_rr[b] + NCH) % NCH))
            win = 1'b0;
        end
        g[c] = win;
      end
    end
    return g;
  endfunction

  task automatic model_commit();
    logic [NCH-1:0] nv;
    logic [31:0]    w;
    int             a;
    nv = '0;
    if (!rst_l) begin
      for (int b = 0; b < NB; b++) m_rr[b] = 0;
      for (int c = 0; c < NCH; c++) begin m_data[c] = '0; m_err[c] = 1'b0; end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (m_gnt[c]) begin
          a = int'(req_addr[c]);
          m_rr[a % NB] = (c + 1) % NCH;
          if (req_we[c]) begin
            if (a < NB * DEPTH) begin
              w = m_mem.exists(a) ? m_mem[a] : 32'h0;
              for (int k = 0; k < 4; k++)
                if (req_wstrb[c][k]) w[8*k +: 8] = req_wdata[c][8*k +: 8];
              m_mem[a] = w;
              if (req_wstrb[c][0]) m_bad[a] = 1'b0;
            end
          end else begin
            nv[c]     = 1'b1;
            m_data[c] = (a < NB * DEPTH) ? m_mem[a] : 32'h0;
            m_err[c]  = (a >= NB * DEPTH) || (m_bad.exists(a) && m_bad[a]);
          end
        end
      end
    end
    m_vld = nv;
  endtask

  always @(posedge clk) model_commit();

  always @(negedge clk) begin
    m_gnt = model_grants();
    cmp("ready", 64'(req_ready), 64'(m_gnt));
    cmp("rsp_valid", 64'(rsp_valid), 64'(m_vld));
    for (int c = 0; c < NCH; c++) begin
      cmp("rsp_rdata", 64'(rsp_rdata[c]), 64'(m_data[c]));
      cmp("rsp_err", 64'(rsp_err[c]), 64'(m_err[c]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int c, input bit v, input bit we, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    req_valid[c] = v;
    req_we[c]    = we;
    req_addr[c]  = a;
    req_wdata[c] = d;
    req_wstrb[c] = s;
  endtask

  task automatic idle();
    for (int c = 0; c < NCH; c++) drive(c, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    // Reset held with requests pending.
    drive(0, 1'b1, 1'b1, 16'h0004, 32'h0BADF00D, 4'hF);
    drive(1, 1'b1, 1'b1, 16'h0008, 32'h12345678, 4'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_ready", 64'(req_ready), 64'h0);
    cmp("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    cmp("rst_rdata0", 64'(rsp_rdata[0]), 64'h0);
    nxt(); rst_l = 1'b1;
    @(negedge clk); cmp("first_grant", 64'(req_ready), 64'h1);
    nxt(); req_valid[0] = 1'b0;
    @(negedge clk); cmp("second_grant", 64'(req_ready), 64'h2);
    nxt(); idle();

    // Write then read back on the other channel.
    drive(0, 1'b1, 1'b1, 16'h0005, 32'hDEADBEEF, 4'hF);
    @(negedge clk); cmp("wr5_grant", 64'(req_ready), 64'h1);
    nxt(); idle(); drive(1, 1'b1, 1'b0, 16'h0005, 32'h0, 4'h0);
    @(negedge clk); cmp("rd5_grant", 64'(req_ready), 64'h2);
    nxt(); idle();
    @(negedge clk);
    cmp("rd5_valid", 64'(rsp_valid), 64'h2);
    cmp("rd5_data", 64'(rsp_rdata[1]), 64'hDEADBEEF);
    cmp("rd5_err", 64'(rsp_err[1]), 64'h0);
    nxt();

    // Same-bank conflict alternates ch0, ch1, ch0, ch1.
    drive(0, 1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cmp("rr_grant", 64'(req_ready), (i % 2 == 0) ? 64'h1 : 64'h2);
      nxt();
    end
    idle();

    // Different banks are served together.
    drive(0, 1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 16'h0005, 32'h0, 4'h0);
    @(negedge clk); cmp("par_grant", 64'(req_ready), 64'h3);
    nxt(); idle();
    @(negedge clk);
    cmp("par_valid", 64'(rsp_valid), 64'h3);
    cmp("par_data0", 64'(rsp_rdata[0]), 64'h0BADF00D);
    cmp("par_data1", 64'(rsp_rdata[1]), 64'hDEADBEEF);
    nxt();

    // Partial write.
    drive(0, 1'b1, 1'b1, 16'h0006, 32'h11223344, 4'hF);
    nxt(); drive(0, 1'b1, 1'b1, 16'h0006, 32'hAABBCCDD, 4'b0101);
    nxt(); idle(); drive(1, 1'b1, 1'b0, 16'h0006, 32'h0, 4'h0);
    nxt(); idle();

    // Freeze: in-flight read still pulses, then data holds, then grants resume.
    freeze = 1'b1;
    drive(0, 1'b1, 1'b0, 16'h0008, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 16'h0005, 32'h0, 4'h0);
    @(negedge clk);
    cmp("frz_ready0", 64'(req_ready), 64'h0);
    cmp("frz_inflight", 64'(rsp_valid), 64'h2);
    cmp("partial_data", 64'(rsp_rdata[1]), 64'h11BB33DD);
    nxt();
    @(negedge clk);
    cmp("frz_ready1", 64'(req_ready), 64'h0);
    cmp("frz_novalid", 64'(rsp_valid), 64'h0);
    cmp("frz_hold", 64'(rsp_rdata[1]), 64'h11BB33DD);
    nxt(); freeze = 1'b0;
    @(negedge clk); cmp("unfrz_grant", 64'(req_ready), 64'h3);
    nxt(); idle();
    @(negedge clk);
    cmp("unfrz_data0", 64'(rsp_rdata[0]), 64'h12345678);
    cmp("unfrz_data1", 64'(rsp_rdata[1]), 64'hDEADBEEF);
    nxt();

    // Out-of-range read and write.
    drive(1, 1'b1, 1'b0, 16'hFFFF, 32'h0, 4'h0);
    @(negedge clk); cmp("oor_grant", 64'(req_ready), 64'h2);
    nxt(); idle();
    @(negedge clk);
    cmp("oor_valid", 64'(rsp_valid), 64'h2);
    cmp("oor_data", 64'(rsp_rdata[1]), 64'h0);
    cmp("oor_err", 64'(rsp_err[1]), 64'h1);
    nxt();
    drive(0, 1'b1, 1'b1, 16'h1004, 32'hFFFFFFFF, 4'hF);
    @(negedge clk); cmp("oorw_grant", 64'(req_ready), 64'h1);
    nxt(); drive(0, 1'b1, 1'b0, 16'h0004, 32'h0, 4'h0);
    nxt(); idle();
    @(negedge clk);
    cmp("oorw_dropped", 64'(rsp_rdata[0]), 64'h0BADF00D);
    cmp("oorw_err", 64'(rsp_err[0]), 64'h0);
    nxt();

    // wstrb = 0 is a no-op write.
    drive(1, 1'b1, 1'b1, 16'h0005, 32'h00000000, 4'h0);
    nxt(); drive(1, 1'b1, 1'b0, 16'h0005, 32'h0, 4'h0);
    nxt(); idle();
    @(negedge clk); cmp("nostrb_data", 64'(rsp_rdata[1]), 64'hDEADBEEF);
    nxt();

    // Read-after-write back-to-back on one channel.
    drive(0, 1'b1, 1'b1, 16'h0007, 32'hCAFEF00D, 4'hF);
    nxt(); drive(0, 1'b1, 1'b0, 16'h0007, 32'h0, 4'h0);
    nxt(); idle();
    @(negedge clk); cmp("raw_data", 64'(rsp_rdata[0]), 64'hCAFEF00D);
    nxt();

`ifdef RV_CCM_PARITY_EN
    // Flip byte-0 parity of addr 0x0005 (bank 1, row 1).
    dut.g_bank[1].u_ram.r_mem[1][32] = ~dut.g_bank[1].u_ram.r_mem[1][32];
    m_bad[5] = 1'b1;
    drive(1, 1'b1, 1'b0, 16'h0005, 32'h0, 4'h0);
    nxt(); idle();
    @(negedge clk);
    cmp("par_err", 64'(rsp_err[1]), 64'h1);
    cmp("par_data", 64'(rsp_rdata[1]), 64'hDEADBEEF);
    nxt();
`endif

    repeat (2) nxt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
